rl_lj_force_accumulator: RTL and testbench

Accumulates the per-pair LJ force stream produced by `RL_LJ_Force_Evaluation_Unit` into one total force per reference particle. It writes each total to external force RAMs through a write-only port. It sits at the output end of the evaluation unit, consuming `ref_particle_id` / `LJ_Force_X/Y/Z` / `forceoutput_valid`. It returns `back_pressure`, which the top-level controller ORs into its existing filter back-pressure term.

---
 rtl/rl_lj_pkg.sv | 98 +++++++++
 rtl/force_acc_fifo.sv | 52 +++++
 rtl/rl_lj_force_accumulator.sv | 163 ++++++++++++++++
 tb/tb_rl_lj_force_accumulator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_lj_pkg.sv
// Shared types for the LJ force accumulator: FSM states, FIFO entry, FP helpers.
package rl_lj_pkg;

  localparam int FE_ID_W   = 20;
  localparam int FE_DATA_W = 32;

  localparam logic [FE_DATA_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD_WAIT,
    ST_FLUSH
  } acc_state_t;

  typedef struct packed {
    logic [FE_ID_W-1:0]   id;
    logic [FE_DATA_W-1:0] fx;
    logic [FE_DATA_W-1:0] fy;
    logic [FE_DATA_W-1:0] fz;
  } force_entry_t;

  typedef struct packed {
    logic [FE_DATA_W-1:0] x;
    logic [FE_DATA_W-1:0] y;
    logic [FE_DATA_W-1:0] z;
  } fp_vec_t;

  // Single-precision add, round-to-nearest-even; denormals flush to zero,
  // Inf/NaN on the larger operand propagate unchanged.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic [7:0]  d;
    logic [27:0] mx, my, m;
    logic [9:0]  e;
    logic [24:0] r;
    logic [4:0]  lz;
    logic        sticky, found, zero;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    mx     = {2'b01, x[22:0], 3'b000};
    my     = {2'b01, y[22:0], 3'b000};
    d      = x[30:23] - y[30:23];
    e      = {2'b00, x[30:23]};
    m      = '0;
    r      = '0;
    lz     = '0;
    sticky = 1'b0;
    found  = 1'b0;
    zero   = 1'b0;
    res    = '0;
    if (x[30:23] == 8'hFF || y[30:23] == 8'h00) begin
      res = x;
    end else begin
      if (d > 8'd26) begin
        my = 28'd1;
      end else begin
        sticky = |(my << (8'd28 - d));
        my     = (my >> d) | {27'b0, sticky};
      end
      if (x[31] == y[31]) begin
        m = mx + my;
        if (m[27]) begin
          m = {1'b0, m[27:2], m[1] | m[0]};
          e = e + 10'd1;
        end
      end else begin
        m = mx - my;
        for (int unsigned i = 0; i < 27; i++) begin
          if (!found && m[5'(26 - i)]) begin
            lz    = 5'(i);
            found = 1'b1;
          end
        end
        if (!found || ({5'b0, lz} >= e)) zero = 1'b1;
        m = m << lz;
        e = e - {5'b0, lz};
      end
      r = {1'b0, m[26:3]} + 25'(m[2] & (m[1] | m[0] | m[3]));
      if (r[24]) begin
        e = e + 10'd1;
        r = r >> 1;
      end
      if (zero)
        res = FP_ZERO;
      else if (e >= 10'd255)
        res = {x[31], 8'hFF, 23'b0};
      else
        res = {x[31], e[7:0], r[22:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/force_acc_fifo.sv
// Show-ahead synchronous FIFO of force entries with occupancy count and sticky overflow.
module force_acc_fifo
  import rl_lj_pkg::*;
#(
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  force_entry_t             push_data,
  input  logic                     pop,
  output force_entry_t             head,
  output logic                     empty,
  output logic [FIFO_ADDR_WIDTH:0] count,
  output logic                     overflow
);

  force_entry_t               mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wptr, rptr;
  logic                       full, push_ok, pop_ok;

  assign full    = (count == (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + FIFO_ADDR_WIDTH'(1);
      if (pop_ok)  rptr <= rptr + FIFO_ADDR_WIDTH'(1);
      // a full FIFO drops the push even when a pop frees a slot this cycle
      if (push && full) overflow <= 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (FIFO_ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (FIFO_ADDR_WIDTH+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/rl_lj_force_accumulator.sv
// Sums the per-pair LJ force stream into one total per reference particle and writes it out.
// Optional ID ordering check built when FORCE_ACC_ORDER_CHECK_EN is defined.
module rl_lj_force_accumulator
  import rl_lj_pkg::*;
#(
  parameter int DATA_WIDTH           = 32,
  parameter int PARTICLE_ID_WIDTH    = 20,
  parameter int FORCE_RAM_ADDR_WIDTH = 7,
  parameter int FIFO_DEPTH           = 32,
  parameter int FIFO_ADDR_WIDTH      = 5,
  parameter int BP_MARGIN            = 4,
  parameter int ADD_LATENCY          = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            forceoutput_valid,
  input  logic [PARTICLE_ID_WIDTH-1:0]    ref_particle_id,
  input  logic [DATA_WIDTH-1:0]           LJ_Force_X,
  input  logic [DATA_WIDTH-1:0]           LJ_Force_Y,
  input  logic [DATA_WIDTH-1:0]           LJ_Force_Z,
  input  logic                            flush,
  output logic                            back_pressure,
  output logic                            force_wr_en,
  output logic [FORCE_RAM_ADDR_WIDTH-1:0] force_wr_addr,
  output logic [DATA_WIDTH-1:0]           force_wr_x,
  output logic [DATA_WIDTH-1:0]           force_wr_y,
  output logic [DATA_WIDTH-1:0]           force_wr_z,
  output logic                            flush_done,
  output logic                            overflow,
  output logic                            order_error
);

  localparam int WCNT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

  force_entry_t                 in_entry, head;
  logic                         fifo_empty, pop, issue;
  logic [FIFO_ADDR_WIDTH:0]     fifo_count;
  acc_state_t                   state;
  logic [DATA_WIDTH-1:0]        acc_x, acc_y, acc_z;
  logic [PARTICLE_ID_WIDTH-1:0] cur_id;
  logic                         acc_valid, flush_pending;
  logic [WCNT_W-1:0]            wait_cnt;
  fp_vec_t                      add_pipe [ADD_LATENCY];

  assign in_entry.id = ref_particle_id;
  assign in_entry.fx = LJ_Force_X;
  assign in_entry.fy = LJ_Force_Y;
  assign in_entry.fz = LJ_Force_Z;

  force_acc_fifo #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (forceoutput_valid),
    .push_data (in_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (overflow)
  );

  assign back_pressure = (fifo_count >= (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH - BP_MARGIN));
  assign pop           = (state == ST_IDLE) && !fifo_empty;
  assign issue         = pop && acc_valid && (head.id == cur_id);

  // Three FP adders; operands captured on issue, result ADD_LATENCY edges later.
  always_ff @(posedge clk) begin
    if (issue) begin
      add_pipe[0].x <= fp_add(acc_x, head.fx);
      add_pipe[0].y <= fp_add(acc_y, head.fy);
      add_pipe[0].z <= fp_add(acc_z, head.fz);
    end
    for (int unsigned i = 1; i < ADD_LATENCY; i++) add_pipe[i] <= add_pipe[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      acc_x         <= FP_ZERO;
      acc_y         <= FP_ZERO;
      acc_z         <= FP_ZERO;
      cur_id        <= '0;
      acc_valid     <= 1'b0;
      flush_pending <= 1'b0;
      wait_cnt      <= '0;
      force_wr_en   <= 1'b0;
      force_wr_addr <= '0;
      force_wr_x    <= FP_ZERO;
      force_wr_y    <= FP_ZERO;
      force_wr_z    <= FP_ZERO;
      flush_done    <= 1'b0;
    end else begin
      force_wr_en <= 1'b0;
      flush_done  <= 1'b0;
      if (flush) flush_pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (acc_valid && head.id == cur_id) begin
              wait_cnt <= '0;
              state    <= ST_ADD_WAIT;
            end else begin
              if (acc_valid) begin
                force_wr_en   <= 1'b1;
                force_wr_addr <= cur_id[FORCE_RAM_ADDR_WIDTH-1:0];
                force_wr_x    <= acc_x;
                force_wr_y    <= acc_y;
                force_wr_z    <= acc_z;
              end
              acc_x     <= head.fx;
              acc_y     <= head.fy;
              acc_z     <= head.fz;
              cur_id    <= head.id;
              acc_valid <= 1'b1;
            end
          end else if (flush_pending) begin
            state <= ST_FLUSH;
          end
        end
        ST_ADD_WAIT: begin
          if (wait_cnt == WCNT_W'(ADD_LATENCY - 1)) begin
            acc_x <= add_pipe[ADD_LATENCY-1].x;
            acc_y <= add_pipe[ADD_LATENCY-1].y;
            acc_z <= add_pipe[ADD_LATENCY-1].z;
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (acc_valid) begin
            force_wr_en   <= 1'b1;
            force_wr_addr <= cur_id[FORCE_RAM_ADDR_WIDTH-1:0];
            force_wr_x    <= acc_x;
            force_wr_y    <= acc_y;
            force_wr_z    <= acc_z;
          end
          acc_valid     <= 1'b0;
          // a flush pulse landing in this very cycle stays pending
          flush_pending <= flush;
          flush_done    <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FORCE_ACC_ORDER_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      order_error <= 1'b0;
    else if (pop && acc_valid && head.id < cur_id)
      order_error <= 1'b1;
  end
`else
  assign order_error = 1'b0;
`endif

endmodule

// File: tb/tb_rl_lj_force_accumulator.sv
// Directed scoreboard bench for rl_lj_force_accumulator.
module tb_rl_lj_force_accumulator;

  localparam int ADD_LAT = 3;
  localparam int DEPTH   = 32;
  localparam logic [31:0] ONE   = 32'h3F80_0000;
  localparam logic [31:0] TWO   = 32'h4000_0000;
  localparam logic [31:0] THREE = 32'h4040_0000;
  localparam logic [31:0] FOUR  = 32'h4080_0000;
  localparam logic [31:0] FIVE  = 32'h40A0_0000;
  localparam logic [31:0] SIX   = 32'h40C0_0000;
  localparam logic [31:0] ZERO  = 32'h0;
`ifdef FORCE_ACC_ORDER_CHECK_EN
  localparam logic ORDER_EN = 1'b1;
`else
  localparam logic ORDER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [19:0] rid = '0;
  logic [31:0] fx = '0, fy = '0, fz = '0;
  logic        flush = 1'b0;
  logic        back_pressure, force_wr_en, flush_done, overflow, order_error;
  logic [6:0]  force_wr_addr;
  logic [31:0] force_wr_x, force_wr_y, force_wr_z;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] x, y, z;
  } exp_wr_t;
  exp_wr_t sb[$];

  always #5 clk = ~clk;

  rl_lj_force_accumulator #(
    .DATA_WIDTH           (32),
    .PARTICLE_ID_WIDTH    (20),
    .FORCE_RAM_ADDR_WIDTH (7),
    .FIFO_DEPTH           (DEPTH),
    .FIFO_ADDR_WIDTH      (5),
    .BP_MARGIN            (4),
    .ADD_LATENCY          (ADD_LAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .forceoutput_valid (valid),
    .ref_particle_id   (rid),
    .LJ_Force_X        (fx),
    .LJ_Force_Y        (fy),
    .LJ_Force_Z        (fz),
    .flush             (flush),
    .back_pressure     (back_pressure),
    .force_wr_en       (force_wr_en),
    .force_wr_addr     (force_wr_addr),
    .force_wr_x        (force_wr_x),
    .force_wr_y        (force_wr_y),
    .force_wr_z        (force_wr_z),
    .flush_done        (flush_done),
    .overflow          (overflow),
    .order_error       (order_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] int_to_fp(input int unsigned n);
    logic [31:0] nn;
    int unsigned msb;
    nn  = n;
    msb = 0;
    for (int i = 0; i < 32; i++) if (nn[i]) msb = i;
    return {1'b0, 8'(127 + msb), 23'((nn << (23 - msb)) & 32'h007F_FFFF)};
  endfunction

  // Write monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    exp_wr_t e;
    if (force_wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(force_wr_en), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(force_wr_addr), 32'(e.addr));
        chk("wr_x", force_wr_x, e.x);
        chk("wr_y", force_wr_y, e.y);
        chk("wr_z", force_wr_z, e.z);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic reset_dut();
    rst = 1'b1; valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [19:0] id, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z);
    valid = 1'b1; rid = id; fx = x; fy = y; fz = z;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_flush_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(force_wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(force_wr_addr), 32'd0);
    chk({tag, "_wr_x"}, force_wr_x, ZERO);
    chk({tag, "_wr_y"}, force_wr_y, ZERO);
    chk({tag, "_wr_z"}, force_wr_z, ZERO);
    chk({tag, "_flush_done"}, 32'(flush_done), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_order_error"}, 32'(order_error), 32'd0);
    chk({tag, "_bp"}, 32'(back_pressure), 32'd0);
  endtask

  initial begin
    int mcount, next_pop, accepted;
    bit mvalid, do_pop, acc_ok;

    reset_dut();
    chk_all_zero("reset");

    // 1: three same-ID forces summed into one write
    sb.push_back('{addr: 7'd5, x: SIX, y: THREE, z: ZERO});
    send(20'd5, ONE, ONE, ZERO);
    send(20'd5, TWO, ONE, ZERO);
    send(20'd5, THREE, ONE, ZERO);
    pulse_flush();
    wait_flush_done("t1_flush_done");

    // 2: ID change writes the previous total before the flush writes the last one
    sb.push_back('{addr: 7'd5, x: TWO, y: ZERO, z: ZERO});
    sb.push_back('{addr: 7'd7, x: FOUR, y: ZERO, z: ZERO});
    send(20'd5, ONE, ZERO, ZERO);
    send(20'd5, ONE, ZERO, ZERO);
    send(20'd7, FOUR, ZERO, ZERO);
    pulse_flush();
    wait_flush_done("t2_flush_done");

    // 3: 48 back-to-back same-ID inputs; occupancy model predicts drops
    mcount = 0; next_pop = 0; mvalid = 1'b0; accepted = 0;
    for (int t = 0; t < 48; t++) begin
      valid = 1'b1; rid = 20'd12; fx = ONE; fy = ZERO; fz = ZERO;
      do_pop = (mcount > 0) && (t >= next_pop);
      if (do_pop) begin
        if (!mvalid) begin
          mvalid   = 1'b1;
          next_pop = t + 1;
        end else begin
          next_pop = t + ADD_LAT + 1;
        end
      end
      acc_ok   = (mcount < DEPTH);
      mcount   = mcount + int'(acc_ok) - int'(do_pop);
      accepted = accepted + int'(acc_ok);
      @(posedge clk); #1;
      chk("t3_bp", 32'(back_pressure), 32'(mcount >= DEPTH - 4));
    end
    valid = 1'b0;
    chk("t3_overflow", 32'(overflow), 32'd1);
    sb.push_back('{addr: 7'd12, x: int_to_fp(accepted), y: ZERO, z: ZERO});
    pulse_flush();
    wait_flush_done("t3_flush_done");
    chk("t3_bp_drained", 32'(back_pressure), 32'd0);

    // 4: decreasing ID is handled as an ID change
    reset_dut();
    chk("t4_overflow_cleared", 32'(overflow), 32'd0);
    sb.push_back('{addr: 7'd9, x: ONE, y: TWO, z: ZERO});
    sb.push_back('{addr: 7'd3, x: FIVE, y: ZERO, z: ONE});
    send(20'd9, ONE, TWO, ZERO);
    send(20'd3, FIVE, ZERO, ONE);
    pulse_flush();
    wait_flush_done("t4_flush_done");
    chk("t4_order_error", 32'(order_error), 32'(ORDER_EN));

    // 5: reset in the middle of ADD_WAIT discards everything
    send(20'd20, ONE, ONE, ONE);
    send(20'd20, ONE, ONE, ONE);
    send(20'd20, ONE, ONE, ONE);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("t5_rst");
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_write", 32'(force_wr_en), 32'd0);
    pulse_flush();
    wait_flush_done("t5_flush_done");

    // 6: flush with nothing accumulated: done pulse two edges after the flush edge
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t6_done_e0", 32'(flush_done), 32'd0);
    @(posedge clk); #1;
    chk("t6_done_e1", 32'(flush_done), 32'd0);
    @(posedge clk); #1;
    chk("t6_done_e2", 32'(flush_done), 32'd1);
    chk("t6_wr_en", 32'(force_wr_en), 32'd0);
    @(posedge clk); #1;
    chk("t6_done_e3", 32'(flush_done), 32'd0);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
